// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    // Default operand/result width and matching iteration-counter width.
    localparam int DIV_WIDTH = 64;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage : div_pkg

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in the dividend MSB, trial-subtract
// the divisor, keep the difference when it does not borrow, emit quotient bit.
module div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] dq_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] dq_o
);

    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+1:0] trial_s;
    logic             borrow_s;

    // Shift/subtract/select datapath for a single quotient bit.
    always_comb begin
        shifted_s = {rem_i, dq_i[WIDTH-1]};
        trial_s   = shifted_s - {2'b00, div_i};
        borrow_s  = trial_s[WIDTH+1];
        if (borrow_s) begin
            rem_o = shifted_s[WIDTH:0];
        end else begin
            rem_o = trial_s[WIDTH:0];
        end
        dq_o = {dq_i[WIDTH-2:0], ~borrow_s};
    end

endmodule : div_step

// File: rtl/iter_divider.sv
// Sequential signed/unsigned integer divider with start/busy/done handshake.
// Fixed latency: done is high WIDTH+1 edges after the accepting edge.
module iter_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             doSigned,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             signed_q, signed_d;
    logic             bzero_q, bzero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remd_q, remd_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   step_rem_s;
    logic [WIDTH-1:0] step_dq_s;

    // Two's-complement negation modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .dq_i  (dq_q),
        .div_i (divisor_q),
        .rem_o (step_rem_s),
        .dq_o  (step_dq_s)
    );

    // Next-state, datapath and output-register updates per state.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        dq_d      = dq_q;
        divisor_d = divisor_q;
        a_raw_d   = a_raw_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        signed_d  = signed_q;
        bzero_d   = bzero_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        quot_d    = quot_q;
        remd_d    = remd_q;
        dbz_d     = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_a_d  = doSigned & A[WIDTH-1];
                    sign_b_d  = doSigned & B[WIDTH-1];
                    signed_d  = doSigned;
                    a_raw_d   = A;
                    dq_d      = (doSigned && A[WIDTH-1]) ? neg_f(A) : A;
                    divisor_d = (doSigned && B[WIDTH-1]) ? neg_f(B) : B;
                    bzero_d   = (B == {WIDTH{1'b0}});
                    rem_d     = {(WIDTH+1){1'b0}};
                    count_d   = CW'(WIDTH - 1);
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                rem_d   = step_rem_s;
                dq_d    = step_dq_s;
                count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
                if (count_q == {CW{1'b0}}) begin
                    state_d = FIX;
                end else begin
                    state_d = RUN;
                end
            end
            FIX: begin
                if (bzero_q) begin
                    quot_d = {WIDTH{1'b0}};
                    remd_d = a_raw_q;
                end else begin
                    quot_d = (signed_q && (sign_a_q ^ sign_b_q)) ? neg_f(dq_q) : dq_q;
                    remd_d = (signed_q && sign_a_q) ? neg_f(rem_q[WIDTH-1:0])
                                                    : rem_q[WIDTH-1:0];
                end
                dbz_d   = bzero_q;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset aborts any operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= {CW{1'b0}};
            rem_q     <= {(WIDTH+1){1'b0}};
            dq_q      <= {WIDTH{1'b0}};
            divisor_q <= {WIDTH{1'b0}};
            a_raw_q   <= {WIDTH{1'b0}};
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            signed_q  <= 1'b0;
            bzero_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= {WIDTH{1'b0}};
            remd_q    <= {WIDTH{1'b0}};
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            dq_q      <= dq_d;
            divisor_q <= divisor_d;
            a_raw_q   <= a_raw_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            signed_q  <= signed_d;
            bzero_q   <= bzero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quot_q    <= quot_d;
            remd_q    <= remd_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = remd_q;
    assign div_by_zero = dbz_q;

endmodule : iter_divider

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed vectors plus random operands
// compared against a magnitude-based arithmetic reference model.
module tb_iter_divider;

    localparam int W = 64;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         doSigned;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total_cnt;
    int bad_cnt;

    iter_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .A           (A),
        .B           (B),
        .doSigned    (doSigned),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division from operand magnitudes.
    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        logic [W-1:0] ma, mb;
        logic na, nb;
        z = (b == 64'd0);
        if (z) begin
            q = 64'd0;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            na = a[W-1];
            nb = b[W-1];
            ma = na ? (64'd0 - a) : a;
            mb = nb ? (64'd0 - b) : b;
            q  = ma / mb;
            r  = ma % mb;
            if (na != nb) q = 64'd0 - q;
            if (na) r = 64'd0 - r;
        end
    endtask

    // Run one division; glitch_at>=0 pulses a competing start at that iteration;
    // start_in_done raises start during the DONE cycle.
    task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input int glitch_at, input logic start_in_done);
        logic [W-1:0] eq, er, pq, pr;
        logic ez, pz, busy_ok, hold_ok;
        int lat;
        ref_div(a, b, s, eq, er, ez);
        pq = quotient;
        pr = remainder;
        pz = div_by_zero;
        @(negedge clk);
        start = 1'b1; A = a; B = b; doSigned = s;
        @(posedge clk); #1;
        start = 1'b0; A = $urandom(); B = $urandom(); doSigned = $urandom_range(0, 1);
        busy_ok = busy;
        hold_ok = 1'b1;
        lat = 0;
        while (lat < 200) begin
            if (lat == glitch_at) begin
                start = 1'b1; A = 64'd50; B = 64'd5; doSigned = 1'b0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            if (quotient !== pq || remainder !== pr || div_by_zero !== pz) hold_ok = 1'b0;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(W + 1));
        chk({tag, ".busy"}, {63'd0, busy_ok & busy}, 64'd1);
        chk({tag, ".hold"}, {63'd0, hold_ok}, 64'd1);
        chk({tag, ".q"}, quotient, eq);
        chk({tag, ".r"}, remainder, er);
        chk({tag, ".dbz"}, {63'd0, div_by_zero}, {63'd0, ez});
        if (start_in_done) begin
            start = 1'b1; A = 64'd9; B = 64'd3; doSigned = 1'b0;
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, ".idle_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, ".idle_done"}, {63'd0, done}, 64'd0);
        if (start_in_done) begin
            @(posedge clk); #1;
            chk({tag, ".no_restart"}, {63'd0, busy}, 64'd0);
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic rs;
        logic saw_done;
        total_cnt = 0;
        bad_cnt   = 0;
        reset = 1'b0; start = 1'b0; A = 64'd0; B = 64'd0; doSigned = 1'b0;
        #12;
        chk("rst.busy", {63'd0, busy}, 64'd0);
        chk("rst.done", {63'd0, done}, 64'd0);
        chk("rst.q", quotient, 64'd0);
        chk("rst.r", remainder, 64'd0);
        chk("rst.dbz", {63'd0, div_by_zero}, 64'd0);
        @(negedge clk); reset = 1'b1;

        do_div("u100_7", 64'd100, 64'd7, 1'b0, -1, 1'b0);
        chk("u100_7.q_const", quotient, 64'd14);
        chk("u100_7.r_const", remainder, 64'd2);
        do_div("sm7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, -1, 1'b0);
        chk("sm7_2.q_const", quotient, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("sm7_2.r_const", remainder, 64'hFFFF_FFFF_FFFF_FFFF);
        do_div("s7_m2", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, -1, 1'b0);
        chk("s7_m2.q_const", quotient, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("s7_m2.r_const", remainder, 64'd1);
        do_div("uall_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, -1, 1'b0);
        do_div("sall_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, -1, 1'b1);
        do_div("dbz_u", 64'h1234, 64'd0, 1'b0, -1, 1'b0);
        chk("dbz_u.r_const", remainder, 64'h1234);
        do_div("dbz_s", 64'h1234, 64'd0, 1'b1, -1, 1'b0);
        do_div("dbz_neg", 64'h8000_0000_0000_0005, 64'd0, 1'b1, -1, 1'b0);
        do_div("ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, -1, 1'b0);
        chk("ovf.q_const", quotient, 64'h8000_0000_0000_0000);
        do_div("glitch", 64'd1000, 64'd3, 1'b0, 10, 1'b0);
        chk("glitch.q_const", quotient, 64'd333);

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; A = 64'd12345; B = 64'd17; doSigned = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort.busy", {63'd0, busy}, 64'd0);
        chk("abort.q", quotient, 64'd0);
        chk("abort.r", remainder, 64'd0);
        saw_done = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        @(negedge clk); reset = 1'b1;
        repeat (80) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        chk("abort.no_done", {63'd0, saw_done}, 64'd0);
        do_div("post_rst", 64'd50, 64'd5, 1'b0, -1, 1'b0);
        chk("post_rst.q_const", quotient, 64'd10);

        // Random operands with a bias toward edge cases.
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            rs = $urandom_range(0, 1);
            case ($urandom_range(0, 5))
                0: rb = 64'(($urandom_range(0, 6)));
                1: rb = rb >> $urandom_range(1, 63);
                2: ra = 64'h8000_0000_0000_0000;
                3: rb = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
                default: ra = ra;
            endcase
            do_div("rand", ra, rb, rs, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule : tb_iter_divider
